alu_issue_ctrl: RTL and testbench

Multicycle issue controller that sits between the instruction decoder and the `alu` datapath. It accepts one decoded ALU instruction (ADD/ADC/ADZ/ADI/NDU/NDC/NDZ) per handshake and reads both operands from the register file over its synchronous read port. It drives the ALU, owns the architectural carry/zero flag register, and performs the conditional register-file writeback that the ALU's condition logic implies. It is the initiator end of the ALU interface: it issues operands and op select, then consumes result and carry.

---
 rtl/alu_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Multicycle issue controller for the ALU: reads both operands,
//            drives the ALU, owns the C/Z flags and does conditional writeback.
//            Optional early condition skip: ALU_CTRL_EARLY_SKIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    opcode,
  input  logic [1:0]    cond,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rc,
  input  logic [5:0]    imm6,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic          alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  output logic          carry_flag,
  output logic          zero_flag,
  output logic          done,
  output logic          illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [3:0]    r_op;
  logic [1:0]    r_cond;
  logic [AW-1:0] r_ra, r_rb, r_rc;
  logic [5:0]    r_imm;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_res;
  logic          r_cout;
  logic          r_pass;
  logic          r_illegal;
  logic          r_c, r_z;

  logic          w_legal_in;
  logic          w_pass_in;
  logic          w_pass_exec;
  logic          w_accept;
  logic [DW-1:0] w_sext;

  // ADI ignores cond and always writes back.
  function automatic logic f_cond_ok(input logic [3:0] op, input logic [1:0] cd,
                                     input logic c, input logic z);
    logic ok;
    ok = 1'b0;
    if (op == OP_ADI) ok = 1'b1;
    else begin
      case (cd)
        2'b00:   ok = 1'b1;
        2'b01:   ok = c;
        2'b10:   ok = z;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  assign w_legal_in  = (opcode == OP_ADD) || (opcode == OP_ADI) || (opcode == OP_NDU);
  assign w_pass_in   = f_cond_ok(opcode, cond, r_c, r_z);
  assign w_pass_exec = f_cond_ok(r_op, r_cond, r_c, r_z);
  assign w_accept    = (r_state == S_IDLE) && instr_valid;
  assign w_sext      = {{(DW-6){r_imm[5]}}, r_imm};

  assign carry_flag  = r_c;
  assign zero_flag   = r_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_op      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (!w_legal_in) w_next = S_WB;
`ifdef ALU_CTRL_EARLY_SKIP_EN
          else if (!w_pass_in) w_next = S_WB;
`endif
          else w_next = S_RDA;
        end
      end
      S_RDA: begin
        rf_raddr = r_ra;
        w_next   = S_RDB;
      end
      S_RDB: begin
        rf_raddr = r_rb;
        w_next   = S_EXEC;
      end
      S_EXEC: begin
        alu_in1 = r_opa;
        alu_in2 = (r_op == OP_ADI) ? w_sext : rf_rdata;
        alu_op  = (r_op == OP_NDU);
        w_next  = S_WB;
      end
      S_WB: begin
        rf_we    = r_pass;
        rf_waddr = (r_op == OP_ADI) ? r_rb : r_rc;
        rf_wdata = r_res;
        done     = 1'b1;
        illegal  = r_illegal;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_cond    <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_imm     <= '0;
      r_opa     <= '0;
      r_res     <= '0;
      r_cout    <= 1'b0;
      r_pass    <= 1'b0;
      r_illegal <= 1'b0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= opcode;
        r_cond    <= cond;
        r_ra      <= ra;
        r_rb      <= rb;
        r_rc      <= rc;
        r_imm     <= imm6;
        r_pass    <= 1'b0;
        r_illegal <= !w_legal_in;
      end
      if (r_state == S_RDB) r_opa <= rf_rdata;
      if (r_state == S_EXEC) begin
        r_res  <= alu_out;
        r_cout <= alu_carry;
        r_pass <= w_pass_exec;
      end
      // NAND-class only touches Z; carry survives.
      if (r_state == S_WB && r_pass) begin
        r_z <= (r_res == '0);
        if (r_op != OP_NDU) r_c <= r_cout;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Self-checking bench for alu_issue_ctrl with register-file/ALU
//            environment and an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

`ifdef ALU_CTRL_EARLY_SKIP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [1:0]  cond;
  logic [2:0]  ra, rb, rc;
  logic [5:0]  imm6;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] alu_in1, alu_in2;
  logic        alu_op;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        carry_flag, zero_flag;
  logic        done, illegal;

  logic [15:0] rf [8];
  logic        bk_we;
  logic [2:0]  bk_addr;
  logic [15:0] bk_data;
  logic [16:0] w_sum;

  int tests = 0;
  int fails = 0;
  logic mc, mz;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(16), .AW(3)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .cond(cond), .ra(ra), .rb(rb), .rc(rc), .imm6(imm6),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .done(done), .illegal(illegal)
  );

  assign w_sum     = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign alu_out   = alu_op ? ~(alu_in1 & alu_in2) : w_sum[15:0];
  assign alu_carry = alu_op ? 1'b0 : w_sum[16];

  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (bk_we) rf[bk_addr] <= bk_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [1:0] cd, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] c, input logic [5:0] im);
    logic [15:0] va, vb, res;
    logic [16:0] s;
    logic        legal, pass, cout;
    int          lat, cyc;
    va    = rf[a];
    vb    = (op == 4'd1) ? {{10{im[5]}}, im} : rf[b];
    legal = (op <= 4'd2);
    pass  = legal && (op == 4'd1 || cd == 2'd0 || (cd == 2'd1 && mc) || (cd == 2'd2 && mz));
    s     = {1'b0, va} + {1'b0, vb};
    res   = (op == 4'd2) ? ~(va & vb) : s[15:0];
    cout  = s[16];
    lat   = (!legal || (EARLY && !pass)) ? 1 : 4;

    @(negedge clk);
    chk("ready_before", {31'd0, instr_ready}, 32'd1);
    opcode = op; cond = cd; ra = a; rb = b; rc = c; imm6 = im; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opcode = 4'($urandom); cond = 2'($urandom); ra = 3'($urandom);
    rb = 3'($urandom); rc = 3'($urandom); imm6 = 6'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 8) begin
      chk("we_before_done", {31'd0, rf_we}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("done", {31'd0, done}, 32'd1);
    chk("we", {31'd0, rf_we}, {31'd0, pass});
    chk("illegal", {31'd0, illegal}, {31'd0, !legal});
    if (pass) begin
      chk("waddr", {29'd0, rf_waddr}, {29'd0, (op == 4'd1) ? b : c});
      chk("wdata", {16'd0, rf_wdata}, {16'd0, res});
    end
    if (pass) begin
      mz = (res == 16'd0);
      if (op != 4'd2) mc = cout;
    end
    @(posedge clk); #1;
    chk("carry", {31'd0, carry_flag}, {31'd0, mc});
    chk("zero", {31'd0, zero_flag}, {31'd0, mz});
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("ready_after", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; cond = '0;
    ra = '0; rb = '0; rc = '0; imm6 = '0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    mc = 1'b0; mz = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'd0;
    #12;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
    chk("rst_alu", {alu_in1, alu_in2}, 32'd0);
    @(negedge clk); reset = 1'b0;

    poke(3'd1, 16'h0003); poke(3'd2, 16'h0005);
    do_instr(4'd0, 2'd0, 3'd1, 3'd2, 3'd3, 6'd0);
    chk("add_r3", {16'd0, rf[3]}, 32'h0008);
    chk("add_flags", {30'd0, carry_flag, zero_flag}, 32'd0);

    do_instr(4'd0, 2'd1, 3'd1, 3'd2, 3'd6, 6'd0);
    chk("adc_c0_nowrite", {16'd0, rf[6]}, 32'h0000);

    poke(3'd1, 16'h8000); poke(3'd2, 16'h8000);
    do_instr(4'd0, 2'd0, 3'd1, 3'd2, 3'd4, 6'd0);
    chk("ovf_flags", {30'd0, carry_flag, zero_flag}, 32'd3);

    poke(3'd1, 16'h0003); poke(3'd2, 16'h0004);
    do_instr(4'd0, 2'd1, 3'd1, 3'd2, 3'd6, 6'd0);
    chk("adc_c1_write", {16'd0, rf[6]}, 32'h0007);

    poke(3'd1, 16'h0001); poke(3'd5, 16'h1234);
    do_instr(4'd1, 2'd3, 3'd1, 3'd5, 3'd7, 6'b111111);
    chk("adi_r5", {16'd0, rf[5]}, 32'h0000);
    chk("adi_flags", {30'd0, carry_flag, zero_flag}, 32'd3);

    poke(3'd1, 16'hFFFF); poke(3'd2, 16'hFFFF);
    do_instr(4'd2, 2'd0, 3'd1, 3'd2, 3'd3, 6'd0);
    chk("ndu_flags", {30'd0, carry_flag, zero_flag}, 32'd3);

    do_instr(4'd7, 2'd0, 3'd1, 3'd2, 3'd3, 6'd0);
    do_instr(4'd0, 2'd3, 3'd1, 3'd2, 3'd3, 6'd0);

    // Abort an ADD in EXEC with an asynchronous reset.
    @(negedge clk);
    opcode = 4'd0; cond = 2'd0; ra = 3'd1; rb = 3'd2; rc = 3'd0; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("exec_alu_in1", {16'd0, alu_in1}, {16'd0, rf[1]});
    reset = 1'b1; #1;
    chk("abort_we", {31'd0, rf_we}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
    chk("abort_alu", {alu_in1, alu_in2}, 32'd0);
    mc = 1'b0; mz = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    poke(3'd1, 16'h0010); poke(3'd2, 16'h0020);
    do_instr(4'd0, 2'd0, 3'd1, 3'd2, 3'd0, 6'd0);
    chk("post_abort_r0", {16'd0, rf[0]}, 32'h0030);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       poke(3'($urandom), 16'h0000);
          1:       poke(3'($urandom), 16'hFFFF);
          default: poke(3'($urandom), 16'($urandom));
        endcase
      end
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      do_instr(op, 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 6'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
